vco_freq_counter: RTL and testbench

VCO_FREQ_COUNTER -- requirements
Module: vco_freq_counter

---
 rtl/vco_freq_counter.sv | 148 ++++++++++++++
 tb/tb_vco_freq_counter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vco_freq_counter.sv
// Multi-channel VCO frequency counter: counts synchronized rising edges of each osc_in bit over a gated window.
// Optional macro VCO_FREQ_COUNTER_CONTINUOUS_EN adds a 'cont' input for back-to-back measurement windows.
module vco_freq_counter #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] osc_in,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic              abort,
`ifdef VCO_FREQ_COUNTER_CONTINUOUS_EN
  input  logic              cont,
`endif
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_count,
  output logic              rd_ovf,
  output logic              busy,
  output logic              done,
  output logic              valid
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

  state_t              state_q, state_d;
  logic                load_gate;
  logic                cont_req;
  logic [NUM_CH-1:0]   osc_meta, osc_sync, osc_prev, osc_rise;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    cnt [NUM_CH];
  logic [NUM_CH-1:0]   ovf;
  logic [CNT_W-1:0]    res_cnt [NUM_CH];
  logic [NUM_CH-1:0]   res_ovf;

`ifdef VCO_FREQ_COUNTER_CONTINUOUS_EN
  assign cont_req = cont;
`else
  assign cont_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A late abort cannot cancel LATCH: the results are already being committed.
  always_comb begin
    state_d   = state_q;
    load_gate = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = ARM;
          load_gate = 1'b1;
        end
      end
      ARM:  state_d = abort ? IDLE : GATE;
      GATE: begin
        if (abort)                          state_d = IDLE;
        else if (gate_cnt == GATE_W'(1))    state_d = LATCH;
      end
      LATCH: begin
        if (cont_req && !abort) begin
          state_d   = ARM;
          load_gate = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      osc_meta <= '0;
      osc_sync <= '0;
      osc_prev <= '0;
    end else begin
      osc_meta <= osc_in;
      osc_sync <= osc_meta;
      osc_prev <= osc_sync;
    end
  end

  assign osc_rise = osc_sync & ~osc_prev;

  // A zero length is promoted to one so the window always contains a GATE cycle.
  always_ff @(posedge clk) begin
    if (rst)                  gate_cnt <= '0;
    else if (load_gate)       gate_cnt <= (gate_len == '0) ? GATE_W'(1) : gate_len;
    else if (state_q == GATE) gate_cnt <= gate_cnt - GATE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (state_q == ARM) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (state_q == GATE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (osc_rise[i]) begin
          if (&cnt[i]) ovf[i] <= 1'b1;
          else         cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) res_cnt[i] <= '0;
      res_ovf <= '0;
    end else if (state_q == LATCH) begin
      for (int i = 0; i < NUM_CH; i++) res_cnt[i] <= cnt[i];
      res_ovf <= ovf;
    end
  end

  // valid survives back-to-back windows; only a fresh start from IDLE clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      done  <= 1'b0;
      valid <= 1'b0;
    end else begin
      done <= (state_q == LATCH);
      if (state_q == LATCH)                    valid <= 1'b1;
      else if (state_q == IDLE && load_gate)   valid <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    rd_count = '0;
    rd_ovf   = 1'b0;
    if (int'(rd_sel) < NUM_CH) begin
      rd_count = res_cnt[rd_sel];
      rd_ovf   = res_ovf[rd_sel];
    end
  end

endmodule

// File: tb/tb_vco_freq_counter.sv
// Testbench for vco_freq_counter: vector table through a scoreboard plus hand-written abort/reset/busy sequences.
module tb_vco_freq_counter;

  localparam int NCH = 3;
  localparam int CW  = 4;
  localparam int GW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] osc_in = '0;
  logic [GW-1:0]  gate_len;
  logic           start;
  logic           abort;
  logic [1:0]     rd_sel;
  logic [CW-1:0]  rd_count;
  logic           rd_ovf, busy, done, valid;
`ifdef VCO_FREQ_COUNTER_CONTINUOUS_EN
  logic           cont;
`endif

  typedef struct {
    int gate;
    int h0, h1, h2;
    int e0, e1, e2;
    bit o0, o1, o2;
    int tol;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];
  int   osc_half[NCH] = '{0, 0, 0};
  int   osc_ph[NCH]   = '{0, 0, 0};
  int   n_vec = 0;
  int   n_miss = 0;
  int   done_count = 0;

  vco_freq_counter #(.NUM_CH(NCH), .CNT_W(CW), .GATE_W(GW)) dut (
    .clk      (clk),
    .rst      (rst),
    .osc_in   (osc_in),
    .gate_len (gate_len),
    .start    (start),
    .abort    (abort),
`ifdef VCO_FREQ_COUNTER_CONTINUOUS_EN
    .cont     (cont),
`endif
    .rd_sel   (rd_sel),
    .rd_count (rd_count),
    .rd_ovf   (rd_ovf),
    .busy     (busy),
    .done     (done),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  // Oscillators toggle every osc_half clocks, offset from the clock edge; zero holds the line low.
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < NCH; c++) begin
      if (osc_half[c] == 0) begin
        osc_in[c] = 1'b0;
        osc_ph[c] = 0;
      end else begin
        osc_ph[c]++;
        if (osc_ph[c] >= osc_half[c]) begin
          osc_ph[c] = 0;
          osc_in[c] = ~osc_in[c];
        end
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_count++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic cmp_tol(input string name, input int act, input int want, input int tol);
    n_vec++;
    if (act < want - tol || act > want + tol) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d", name, act, want, tol);
    end
  endtask

  task automatic set_osc(input int h0, input int h1, input int h2);
    osc_half[0] = h0;
    osc_half[1] = h1;
    osc_half[2] = h2;
    repeat (12) @(negedge clk);
  endtask

  task automatic apply_stimulus(input vec_t v);
    set_osc(v.h0, v.h1, v.h2);
    gate_len = GW'(v.gate);
    start    = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start    = 1'b0;
  endtask

  // lat counts negedges since the start was driven; budget bounds the wait.
  task automatic wait_done(input int lat0, input int budget, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_ch(input int ch, input int want, input bit want_ovf, input int tol);
    rd_sel = 2'(ch);
    #1;
    cmp_tol($sformatf("rd_count_ch%0d", ch), int'(rd_count), want,
            (want_ovf || want == 0) ? 0 : tol);
    cmp($sformatf("rd_ovf_ch%0d", ch), int'(rd_ovf), int'(want_ovf));
  endtask

  task automatic check_output(input int lat);
    vec_t v;
    int   eff;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
      return;
    end
    v   = sb.pop_front();
    eff = (v.gate == 0) ? 1 : v.gate;
    cmp("done_latency", lat, eff + 3);
    cmp("valid_after_done", int'(valid), 1);
    check_ch(0, v.e0, v.o0, v.tol);
    check_ch(1, v.e1, v.o1, v.tol);
    check_ch(2, v.e2, v.o2, v.tol);
    rd_sel = 2'd3;
    #1;
    cmp("rd_count_sel3", int'(rd_count), 0);
    cmp("rd_ovf_sel3", int'(rd_ovf), 0);
    @(negedge clk);
    cmp("done_pulse_width", int'(done), 0);
  endtask

  initial begin
    int lat;
    int dc;
    start    = 1'b0;
    abort    = 1'b0;
    gate_len = '0;
    rd_sel   = '0;
`ifdef VCO_FREQ_COUNTER_CONTINUOUS_EN
    cont     = 1'b0;
`endif
    vecs[0] = '{100, 5, 0, 0, 10, 0, 0, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{60,  3, 10, 5, 10, 3, 6, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{40,  4, 0, 1, 5, 0, 15, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{0,   0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{200, 0, 2, 0, 0, 15, 0, 1'b0, 1'b1, 1'b0, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_done", int'(done), 0);
    cmp("reset_valid", int'(valid), 0);
    cmp("reset_rd_count", int'(rd_count), 0);
    cmp("reset_rd_ovf", int'(rd_ovf), 0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i]);
      wait_done(1, ((vecs[i].gate == 0) ? 1 : vecs[i].gate) + 20, lat);
      check_output(lat);
    end
    #1;
    cmp("done_count_table", done_count, 5);

    // abort together with start in IDLE: stays idle, results still valid
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cmp("abort_start_busy", int'(busy), 0);
    cmp("abort_start_valid", int'(valid), 1);

    // abort 20 cycles into a 100-cycle window
    set_osc(5, 0, 0);
    #1;
    dc = done_count;
    gate_len = GW'(100);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (20) @(negedge clk);
    cmp("busy_before_abort", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cmp("busy_after_abort", int'(busy), 0);
    cmp("valid_after_abort", int'(valid), 0);
    repeat (120) @(negedge clk);
    #1;
    cmp("done_count_abort", done_count, dc);
    check_ch(1, 15, 1'b1, 0);
    check_ch(0, 0, 1'b0, 0);

    // a second start during GATE must not restart or stretch the window
    set_osc(3, 0, 0);
    gate_len = GW'(30);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (9) @(negedge clk);
    gate_len = GW'(200);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(11, 60, lat);
    cmp("ignored_start_latency", lat, 33);
    cmp("ignored_start_valid", int'(valid), 1);
    check_ch(0, 5, 1'b0, 1);

    // reset in the middle of GATE
    set_osc(5, 0, 0);
    #1;
    dc = done_count;
    gate_len = GW'(100);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd_sel = 2'd0;
    #1;
    cmp("midrst_busy", int'(busy), 0);
    cmp("midrst_done", int'(done), 0);
    cmp("midrst_valid", int'(valid), 0);
    cmp("midrst_rd_count", int'(rd_count), 0);
    rst = 1'b0;
    @(negedge clk);
    cmp("postrst_busy", int'(busy), 0);
    cmp("postrst_valid", int'(valid), 0);
    repeat (120) @(negedge clk);
    #1;
    cmp("done_count_midrst", done_count, dc);
    apply_stimulus(vecs[0]);
    wait_done(1, 120, lat);
    check_output(lat);

`ifdef VCO_FREQ_COUNTER_CONTINUOUS_EN
    set_osc(0, 0, 0);
    cont     = 1'b1;
    gate_len = GW'(50);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(1, 80, lat);
    cmp("cont_first_latency", lat, 53);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wait_done(1, 80, lat);
      cmp("cont_period", lat, 52);
    end
    cont = 1'b0;
    @(negedge clk);
    wait_done(1, 80, lat);
    cmp("cont_last_period", lat, 52);
    #1;
    dc = done_count;
    @(negedge clk);
    cmp("cont_stop_busy", int'(busy), 0);
    repeat (100) @(negedge clk);
    #1;
    cmp("cont_stop_done_count", done_count, dc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
